// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares the single port of a pointer-addressed byte buffer
// among NUM_REQ requesters. Each transaction takes three cycles: IDLE (arbitrate), ISSUE and CAPTURE.
module ram_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 2048,
    parameter int LW      = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ-1:0]     i_we,
    input  logic [8*NUM_REQ-1:0]   i_wdata,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [NUM_REQ-1:0]     o_nack,
    output logic [NUM_REQ-1:0]     o_rvalid,
    output logic [7:0]             o_rdata,
    output logic [LW-1:0]          o_level,
    output logic                   o_busy,
    output logic                   o_ram_wr_en,
    output logic                   o_ram_rd_en,
    output logic [7:0]             o_ram_data_in,
    input  logic [7:0]             i_ram_data_out,
    output logic [1:0]             o_state
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [IW-1:0]        r_rr_ptr;
    logic [NUM_REQ-1:0]   r_win_oh;
    logic                 r_we;
    logic                 r_refuse;
    logic [LW-1:0]        r_level;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_nack;
    logic [NUM_REQ-1:0]   r_rvalid;
    logic [7:0]           r_rdata;
    logic                 r_busy;
    logic                 r_ram_wr_en;
    logic                 r_ram_rd_en;
    logic [7:0]           r_ram_data_in;

    logic                 w_found;
    logic [IW:0]          w_idx;
    logic [IW-1:0]        w_win;
    logic [IW-1:0]        w_next_ptr;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic                 w_win_we;
    logic                 w_refuse;
    logic [7:0]           w_win_byte;

    // First requester at or above rr_ptr, wrapping; w_idx stays below 2*NUM_REQ so one subtraction suffices.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NUM_REQ))
                w_idx = w_idx - (IW+1)'(NUM_REQ);
            if (!w_found && i_req[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IW-1:0];
            end
        end
    end

    assign w_next_ptr = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + IW'(1);
    assign w_win_oh   = NUM_REQ'(1) << w_win;
    assign w_win_we   = i_we[w_win];
    assign w_win_byte = i_wdata[{w_win, 3'b000} +: 8];
    assign w_refuse   = w_win_we ? (r_level == LW'(DEPTH)) : (r_level == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // A request is a level held by the requester until its gnt pulse; req is only sampled in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|i_req) w_next_state = ISSUE;
            ISSUE:   w_next_state = CAPTURE;
            CAPTURE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_win_oh      <= '0;
            r_we          <= 1'b0;
            r_refuse      <= 1'b0;
            r_level       <= '0;
            r_gnt         <= '0;
            r_nack        <= '0;
            r_rvalid      <= '0;
            r_rdata       <= '0;
            r_busy        <= 1'b0;
            r_ram_wr_en   <= 1'b0;
            r_ram_rd_en   <= 1'b0;
            r_ram_data_in <= '0;
        end else begin
            r_gnt       <= '0;
            r_nack      <= '0;
            r_rvalid    <= '0;
            r_ram_wr_en <= 1'b0;
            r_ram_rd_en <= 1'b0;
            r_busy      <= (w_next_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_win_oh    <= w_win_oh;
                        r_we        <= w_win_we;
                        r_refuse    <= w_refuse;
                        r_rr_ptr    <= w_next_ptr;
                        r_gnt       <= w_win_oh;
                        r_nack      <= w_refuse ? w_win_oh : '0;
                        r_ram_wr_en <= w_win_we && !w_refuse;
                        r_ram_rd_en <= !w_win_we && !w_refuse;
                        if (w_win_we && !w_refuse)
                            r_ram_data_in <= w_win_byte;
                    end
                end
                ISSUE: begin
                    if (!r_refuse)
                        r_level <= r_we ? r_level + LW'(1) : r_level - LW'(1);
                end
                CAPTURE: begin
                    if (!r_we && !r_refuse) begin
                        r_rdata  <= i_ram_data_out;
                        r_rvalid <= r_win_oh;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_gnt         = r_gnt;
    assign o_nack        = r_nack;
    assign o_rvalid      = r_rvalid;
    assign o_rdata       = r_rdata;
    assign o_level       = r_level;
    assign o_busy        = r_busy;
    assign o_ram_wr_en   = r_ram_wr_en;
    assign o_ram_rd_en   = r_ram_rd_en;
    assign o_ram_data_in = r_ram_data_in;
    assign o_state       = r_state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a buffer RAM model, a timeline model of the arbiter that is compared
// every cycle, and directed scenarios with hand-computed expectations.
module tb_ram_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 2048;
    localparam int LW      = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   i_req = '0;
    logic [NUM_REQ-1:0]   i_we = '0;
    logic [8*NUM_REQ-1:0] i_wdata = '0;
    logic [NUM_REQ-1:0]   o_gnt, o_nack, o_rvalid;
    logic [7:0]           o_rdata;
    logic [LW-1:0]        o_level;
    logic                 o_busy, o_ram_wr_en, o_ram_rd_en;
    logic [7:0]           o_ram_data_in, i_ram_data_out;
    logic [1:0]           o_state;

    int n_pass  = 0;
    int n_total = 0;

    ram_port_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .LW(LW)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_wdata(i_wdata),
        .o_gnt(o_gnt), .o_nack(o_nack), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
        .o_level(o_level), .o_busy(o_busy), .o_ram_wr_en(o_ram_wr_en),
        .o_ram_rd_en(o_ram_rd_en), .o_ram_data_in(o_ram_data_in),
        .i_ram_data_out(i_ram_data_out), .o_state(o_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- buffer RAM model ----------------
    logic [7:0]  ram_mem [0:DEPTH-1];
    logic [10:0] ram_wp, ram_rp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_wp <= '0;
            ram_rp <= '0;
            i_ram_data_out <= '0;
        end else begin
            if (o_ram_wr_en) begin
                ram_mem[ram_wp] <= o_ram_data_in;
                ram_wp <= ram_wp + 11'd1;
            end
            if (o_ram_rd_en) begin
                i_ram_data_out <= ram_mem[ram_rp];
                ram_rp <= ram_rp + 11'd1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Timeline model: each arbitration at edge n schedules its outputs on absolute cycle numbers.
    logic [7:0]         m_q[$];
    int                 cyc = 0;
    int                 next_arb = 0;
    int                 last_arb = -10;
    int                 m_rr = 0;
    int                 m_level = 0;
    logic [7:0]         m_rdata = '0;
    int                 pend_lvl_cyc = -1;
    int                 pend_lvl = 0;
    int                 pend_rd_cyc = -1;
    logic [7:0]         pend_rd = '0;
    logic [NUM_REQ-1:0] exp_gnt [int];
    logic [NUM_REQ-1:0] exp_nack [int];
    logic [NUM_REQ-1:0] exp_rv [int];
    logic               exp_wr [int];
    logic               exp_rd [int];
    logic [7:0]         exp_din [int];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            cyc = 0; next_arb = 0; last_arb = -10; m_rr = 0; m_level = 0; m_rdata = '0;
            pend_lvl_cyc = -1; pend_rd_cyc = -1;
            exp_gnt.delete(); exp_nack.delete(); exp_rv.delete();
            exp_wr.delete(); exp_rd.delete(); exp_din.delete();
        end else begin
            cyc++;
            if (cyc == pend_lvl_cyc) m_level = pend_lvl;
            if (cyc == pend_rd_cyc) m_rdata = pend_rd;
            if (cyc >= next_arb && i_req != '0) begin
                int w;
                logic is_wr, refused;
                logic [7:0] b;
                w = -1;
                for (int k = 0; k < NUM_REQ; k++)
                    if (w < 0 && i_req[(m_rr + k) % NUM_REQ]) w = (m_rr + k) % NUM_REQ;
                is_wr = i_we[w];
                b = i_wdata[8*w +: 8];
                refused = is_wr ? (m_q.size() == DEPTH) : (m_q.size() == 0);
                exp_gnt[cyc] = NUM_REQ'(1) << w;
                if (refused) exp_nack[cyc] = NUM_REQ'(1) << w;
                else if (is_wr) begin
                    exp_wr[cyc] = 1'b1;
                    exp_din[cyc] = b;
                    m_q.push_back(b);
                end else begin
                    exp_rd[cyc] = 1'b1;
                    pend_rd = m_q.pop_front();
                    pend_rd_cyc = cyc + 2;
                    exp_rv[cyc + 2] = NUM_REQ'(1) << w;
                end
                pend_lvl = m_q.size();
                pend_lvl_cyc = cyc + 1;
                next_arb = cyc + 3;
                last_arb = cyc;
                m_rr = (w + 1) % NUM_REQ;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_gnt", o_gnt, exp_gnt.exists(cyc) ? exp_gnt[cyc] : '0);
        chk("m_nack", o_nack, exp_nack.exists(cyc) ? exp_nack[cyc] : '0);
        chk("m_rvalid", o_rvalid, exp_rv.exists(cyc) ? exp_rv[cyc] : '0);
        chk("m_wr_en", o_ram_wr_en, exp_wr.exists(cyc) ? 1 : 0);
        chk("m_rd_en", o_ram_rd_en, exp_rd.exists(cyc) ? 1 : 0);
        if (exp_din.exists(cyc)) chk("m_data_in", o_ram_data_in, exp_din[cyc]);
        chk("m_level", o_level, m_level);
        chk("m_rdata", o_rdata, m_rdata);
        chk("m_busy", o_busy, (cyc >= last_arb && cyc - last_arb <= 1) ? 1 : 0);
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic [NUM_REQ-1:0] req_hold);
        @(negedge clk);
        i_req = req_hold;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_gnt(output logic [NUM_REQ-1:0] g, output longint t);
        g = '0;
        t = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_gnt != '0) begin
                g = o_gnt;
                t = $time;
                break;
            end
        end
        if (g == '0) chk("gnt_timeout", 0, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [NUM_REQ-1:0] g;
        longint t, t_prev;
        logic [3:0] exp_seq [0:4];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        rst = 1'b1;

        // Round-robin order from reset with all requesters asking
        i_we = 4'b1111;
        i_wdata = 32'h44332211;
        do_reset(4'b1111);
        #1;
        chk("rst_level", o_level, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_gnt", o_gnt, 0);
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(g, t);
            chk("rr_gnt", g, exp_seq[i]);
            if (i > 0) chk("rr_spacing", 32'(t - t_prev), 30);
            t_prev = t;
        end
        i_req = '0;

        // Requester 2 write then read of the same byte
        do_reset('0);
        i_req = 4'b0100; i_we = 4'b0100; i_wdata = 32'h00A50000;
        wait_gnt(g, t);
        chk("wr_gnt", g, 4'b0100);
        chk("wr_en", o_ram_wr_en, 1);
        chk("wr_din", o_ram_data_in, 8'hA5);
        i_req = '0;
        @(negedge clk);
        chk("wr_level", o_level, 1);
        i_req = 4'b0100; i_we = '0;
        wait_gnt(g, t);
        chk("rd_gnt", g, 4'b0100);
        chk("rd_en", o_ram_rd_en, 1);
        i_req = '0;
        @(negedge clk);
        chk("rd_level", o_level, 0);
        @(negedge clk);
        chk("rd_rvalid", o_rvalid, 4'b0100);
        chk("rd_rdata", o_rdata, 8'hA5);

        // Read from an empty buffer is refused
        do_reset('0);
        i_req = 4'b0001; i_we = '0;
        wait_gnt(g, t);
        chk("empty_gnt", g, 4'b0001);
        chk("empty_nack", o_nack, 4'b0001);
        chk("empty_wr_en", o_ram_wr_en, 0);
        chk("empty_rd_en", o_ram_rd_en, 0);
        i_req = '0;
        repeat (2) begin
            @(negedge clk);
            chk("empty_rvalid", o_rvalid, 0);
            chk("empty_level", o_level, 0);
        end

        // Fill to DEPTH, refuse one more write, then drain one and refill
        do_reset('0);
        i_we = 4'b0001; i_wdata = 32'h00000011;
        i_req = 4'b0001;
        for (int i = 0; i < DEPTH; i++) begin
            wait_gnt(g, t);
            i_wdata[7:0] = 8'(i + 1 + 'h11);
        end
        wait_gnt(g, t);
        chk("full_level", o_level, DEPTH);
        chk("full_gnt", g, 4'b0001);
        chk("full_nack", o_nack, 4'b0001);
        chk("full_wr_en", o_ram_wr_en, 0);
        i_we = '0;
        wait_gnt(g, t);
        chk("full_rd_en", o_ram_rd_en, 1);
        i_req = '0;
        @(negedge clk);
        chk("drain_level", o_level, DEPTH - 1);
        @(negedge clk);
        chk("drain_rdata", o_rdata, 8'h11);
        i_req = 4'b0001; i_we = 4'b0001; i_wdata[7:0] = 8'h99;
        wait_gnt(g, t);
        chk("refill_nack", o_nack, 0);
        chk("refill_wr_en", o_ram_wr_en, 1);
        i_req = '0;
        @(negedge clk);
        chk("refill_level", o_level, DEPTH);

        // Requester 1 read and requester 3 write contend with rr_ptr = 1
        do_reset('0);
        i_req = 4'b0001; i_we = 4'b0001; i_wdata = 32'h0000003C;
        wait_gnt(g, t);
        i_req = 4'b1010; i_we = 4'b1000; i_wdata = 32'h77000000;
        wait_gnt(g, t_prev);
        chk("rr1_gnt", g, 4'b0010);
        chk("rr1_rd_en", o_ram_rd_en, 1);
        i_req = 4'b1000;
        repeat (2) @(negedge clk);
        chk("rr1_rvalid", o_rvalid, 4'b0010);
        chk("rr1_rdata", o_rdata, 8'h3C);
        wait_gnt(g, t);
        chk("rr3_gnt", g, 4'b1000);
        chk("rr3_spacing", 32'(t - t_prev), 30);
        chk("rr3_din", o_ram_data_in, 8'h77);
        i_req = '0;

        // Reset during the ISSUE cycle of a read
        do_reset('0);
        i_req = 4'b0010; i_we = 4'b0010; i_wdata = 32'h00005A00;
        wait_gnt(g, t);
        i_req = 4'b0010; i_we = '0;
        wait_gnt(g, t);
        chk("abort_rd_en_pre", o_ram_rd_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_rd_en", o_ram_rd_en, 0);
        chk("abort_gnt", o_gnt, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_level", o_level, 0);
        i_req = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_rvalid", o_rvalid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter sharing the 2048 x 8 pointer-addressed data buffer (FIFO-style RAM with wr_en/rd_en, auto-incrementing write/read pointers, registered data_out) among NUM_REQ on-chip requesters (UART, SPI, DMA, core). The block accepts one write or read request per transaction and drives the RAM's single port. It keeps its own authoritative occupancy count and refuses writes when the buffer is full and reads when it is empty. Read data returns to the winning requester with a one-hot valid pulse.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- DEPTH, 2048: buffer capacity in bytes; must match the RAM.
- LW, 12: level width; must satisfy 2^LW > DEPTH.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester request; held until gnt.
- we  in  NUM_REQ  per-requester op: 1 = write, 0 = read; valid while req is high.
- wdata  in  8*NUM_REQ  write byte of requester i at bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- nack  out  NUM_REQ  one-hot, one-cycle pulse together with gnt when the request is refused.
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse; rdata valid for requester i.
- rdata  out  8  read byte; holds its value until the next successful read.
- level  out  LW  current occupancy, 0..DEPTH.
- busy  out  1  high whenever state != IDLE.
- ram_wr_en  out  1  RAM write enable.
- ram_rd_en  out  1  RAM read enable.
- ram_data_in  out  8  RAM write data.
- ram_data_out  in  8  RAM registered read data.

## Operation
- All outputs are registered. Reset values: gnt = 0, nack = 0, rvalid = 0, rdata = 0, level = 0, busy = 0, ram_wr_en = 0, ram_rd_en = 0, ram_data_in = 0. Reset also sets state = IDLE and rr_ptr = 0.
- FSM states are IDLE, ISSUE, CAPTURE.
- IDLE:
  - If any req bit is high, pick the winner w: the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch w, we[w] and wdata[w]. Set rr_ptr <= (w+1) mod NUM_REQ. Go to ISSUE.
  - If no req bit is high, stay in IDLE.
- Refusal is evaluated against the level at the IDLE edge:
  - A write with level == DEPTH is refused.
  - A read with level == 0 is refused.
- ISSUE (one cycle):
  - gnt[w] = 1.
  - Accepted write: ram_wr_en = 1, ram_data_in = latched byte.
  - Accepted read: ram_rd_en = 1.
  - Refused request: nack[w] = 1 and both RAM enables stay 0.
  - At the end of ISSUE, level increments for an accepted write, decrements for an accepted read, and is unchanged on refusal. Go to CAPTURE.
- CAPTURE (one cycle): RAM enables are 0 and ram_data_out is valid. At the end of the cycle:
  - Accepted read: rdata <= ram_data_out and rvalid[w] <= 1.
  - Go to IDLE.
- Requester rule: drop req at the edge after seeing gnt, or keep it high to issue a new request. The arbiter ignores req outside IDLE.
- Round-robin fairness: with all requesters continuously requesting, the grant order is 0,1,..,NUM_REQ-1,0,.. starting from rr_ptr. No requester waits more than NUM_REQ transactions.
- Level arithmetic is unsigned LW-bit. It never wraps, because refusal prevents overflow and underflow.

## Timing
- One transaction every 3 cycles; maximum throughput is 1 byte per 3 clk.
- Let req be sampled at edge E0. Then gnt/nack are high in cycle E0..E1, level is updated at E1, and rvalid/rdata are high in cycle E2..E3 (the next IDLE cycle).
- A new arbitration may occur in the same IDLE cycle in which rvalid is asserted.
- A write followed by a read of the same byte needs no extra gap: level is already updated when the next IDLE samples.
- An asynchronous reset mid-transaction aborts it:
  - No further gnt/rvalid is issued for that transaction.
  - A RAM enable already asserted is cleared immediately.
  - The RAM is reset by the same rst, so level = 0 stays consistent with it.

## Test plan
- Reset with req = 4'b1111 held → after release: level = 0 and busy = 0. First gnt = 4'b0001, then 0010, 0100, 1000, 0001, each 3 cycles apart.
- Requester 2 writes 0xA5, then reads → ram_wr_en pulses with ram_data_in = 0xA5 and level goes 0→1. Then ram_rd_en pulses, rvalid = 4'b0100 with rdata = 0xA5 two cycles after gnt, and level = 0.
- Read with level = 0 → gnt and nack pulse on the same cycle, both RAM enables stay 0, rvalid stays 0, and level stays 0.
- 2048 writes from requester 0, then a 2049th → level = 2048 and the last request gets nack with ram_wr_en = 0. One read → level = 2047, and the next write is accepted.
- Requester 1 reads while requester 3 writes, rr_ptr = 1 → requester 1 is served first. Requester 3 gets gnt exactly 3 cycles later, and the read data equals the earliest byte written.
- rst asserted in the ISSUE cycle of a read → ram_rd_en, gnt, busy and level drop to 0 immediately, and rvalid never pulses.
